// File: rtl/prtc_pkg.sv
// prtc_pkg: op encodings, C034 bit positions, command prefixes and sequencer states
package prtc_pkg;

   typedef enum logic [1:0] {
      OP_BRAM_RD = 2'd0,
      OP_BRAM_WR = 2'd1,
      OP_CLK_RD  = 2'd2,
      OP_CLK_WR  = 2'd3
   } op_e;

   localparam int C034_START = 7;
   localparam int C034_READ  = 6;

   localparam logic [3:0] BRAM_EXT_PFX = 4'b0111;
   localparam logic [2:0] CLK_PFX      = 3'b000;
   localparam logic [1:0] CLK_SFX      = 2'b01;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD_A,
      S_CTL_A,
      S_CMD_B,
      S_CTL_B,
      S_DATA,
      S_CTL_D,
      S_RD_ADDR,
      S_RD_CAP,
      S_DONE
   } state_e;

   function automatic logic op_is_rd(input op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_clk(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/prtc_cmd_encode.sv
// prtc_cmd_encode: maps sequencer state and latched request to the PRTC address/data lines
module prtc_cmd_encode
   import prtc_pkg::*;
(
   input  state_e     state_i,
   input  op_e        op_i,
   input  logic [7:0] index_i,
   input  logic [7:0] wdata_i,
   output logic       addr_o,
   output logic [7:0] din_o
);

   logic       rd;
   logic [7:0] ctl;

   // every C034 write carries start plus the read flag, since the PRTC keeps the last C034 bit 6
   always_comb begin
      rd              = op_is_rd(op_i);
      ctl             = 8'h00;
      ctl[C034_START] = 1'b1;
      ctl[C034_READ]  = rd;
      addr_o          = 1'b0;
      din_o           = 8'h00;
      case (state_i)
         S_CMD_A: din_o = op_is_clk(op_i) ? {rd, CLK_PFX, index_i[1:0], CLK_SFX}
                                          : {rd, BRAM_EXT_PFX, index_i[7:5]};
         S_CMD_B: din_o = {rd, index_i[4:0], 2'b00};
         S_DATA:  din_o = wdata_i;
         S_CTL_A, S_CTL_B, S_CTL_D: begin
            addr_o = 1'b1;
            din_o  = ctl;
         end
         default: din_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/prtc_seq_arbiter.sv
// prtc_seq_arbiter: shares the PRTC C033/C034 port between the CPU and an internal byte sequencer
module prtc_seq_arbiter
   import prtc_pkg::*;
#(
   parameter int GUARD_CYCLES = 64,
   parameter int GW           = 8
) (
   input  logic       CLK_14M,
   input  logic       reset,
   input  logic       cen,
   input  logic       cpu_addr,
   input  logic       cpu_rw,
   input  logic [7:0] cpu_din,
   input  logic       cpu_strobe,
   output logic [7:0] cpu_dout,
   output logic       cpu_collision,
   output logic       prtc_addr,
   output logic       prtc_rw,
   output logic [7:0] prtc_din,
   output logic       prtc_strobe,
   input  logic [7:0] prtc_dout,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_index,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy
);

   localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYCLES);

   state_e        state_q, state_d;
   logic [GW-1:0] guard_q, guard_d;
   op_e           op_q;
   logic [7:0]    idx_q, wdata_q, rsp_data_q, rsp_data_d;
   logic          idle, quiet, accept, seq_beat, enc_addr;
   logic [7:0]    enc_din;

   prtc_cmd_encode u_enc (
      .state_i (state_q),
      .op_i    (op_q),
      .index_i (idx_q),
      .wdata_i (wdata_q),
      .addr_o  (enc_addr),
      .din_o   (enc_din)
   );

   // CPU-quiet guard, acceptance and the CPU/sequencer port mux
   always_comb begin
      idle          = state_q == S_IDLE;
      quiet         = guard_q == GUARD_MAX;
      req_ready     = idle & quiet & ~cpu_strobe;
      accept        = req_valid & req_ready & cen;
      guard_d       = !cen ? guard_q : cpu_strobe ? '0 : quiet ? guard_q : guard_q + GW'(1);
      seq_beat      = cen & ((state_q == S_CMD_A) | (state_q == S_CTL_A) | (state_q == S_CMD_B) |
                             (state_q == S_CTL_B) | (state_q == S_CTL_D) |
                             ((state_q == S_DATA) & ~op_is_rd(op_q)));
      busy          = ~idle;
      prtc_strobe   = idle ? cpu_strobe : seq_beat;
      prtc_rw       = idle ? ~(cpu_strobe & ~cpu_rw) : ~seq_beat;
      prtc_addr     = idle ? cpu_addr : enc_addr;
      prtc_din      = idle ? cpu_din : enc_din;
      cpu_dout      = prtc_dout;
      cpu_collision = ~idle & cpu_strobe & cen;
      rsp_valid     = state_q == S_DONE;
      rsp_data      = rsp_data_q;
      rsp_data_d    = accept ? 8'h00 : (state_q == S_RD_CAP) ? prtc_dout : rsp_data_q;
   end

   // beat sequencer; clock ops skip the second command pair, writes skip the read capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    state_d = accept ? S_CMD_A : S_IDLE;
         S_CMD_A:   state_d = cen ? S_CTL_A : S_CMD_A;
         S_CTL_A:   state_d = !cen ? S_CTL_A : op_is_clk(op_q) ? S_DATA : S_CMD_B;
         S_CMD_B:   state_d = cen ? S_CTL_B : S_CMD_B;
         S_CTL_B:   state_d = cen ? S_DATA : S_CTL_B;
         S_DATA:    state_d = cen ? S_CTL_D : S_DATA;
         S_CTL_D:   state_d = !cen ? S_CTL_D : op_is_rd(op_q) ? S_RD_ADDR : S_DONE;
         S_RD_ADDR: state_d = S_RD_CAP;
         S_RD_CAP:  state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   // state, guard counter and latched request
   always_ff @(posedge CLK_14M) begin
      if (reset) begin
         state_q    <= S_IDLE;
         guard_q    <= '0;
         op_q       <= OP_BRAM_RD;
         idx_q      <= 8'h00;
         wdata_q    <= 8'h00;
         rsp_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         guard_q    <= guard_d;
         rsp_data_q <= rsp_data_d;
         if (accept) begin
            op_q    <= op_e'(req_op);
            idx_q   <= req_index;
            wdata_q <= req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_prtc_seq_arbiter.sv
// tb_prtc_seq_arbiter: scoreboard bench with a behavioural PRTC register model
module tb_prtc_seq_arbiter;

   localparam int GUARD = 64;

   logic       clk = 1'b0, reset = 1'b1, cen;
   logic       cpu_addr = 1'b0, cpu_rw = 1'b1, cpu_strobe = 1'b0, req_valid = 1'b0;
   logic [7:0] cpu_din = 8'h00, req_index = 8'h00, req_wdata = 8'h00;
   logic [1:0] req_op = 2'd0;
   logic [7:0] cpu_dout, prtc_din, prtc_dout, rsp_data;
   logic       cpu_collision, prtc_addr, prtc_rw, prtc_strobe, req_ready, rsp_valid, busy;
   logic [1:0] cyc = 2'd0;

   int pass_cnt = 0, tot_cnt = 0;
   int rsp_cnt = 0, coll_cnt = 0, leak_cnt = 0;
   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];

   logic [7:0]  c033 = 8'h00;
   logic [7:0]  pram [256];
   logic [31:0] clk_data = 32'h12345678;
   logic [1:0]  ph = 2'd0, sel = 2'd0;
   logic [2:0]  hi = 3'd0;
   logic [7:0]  ad = 8'h00;
   logic        isclk = 1'b0;

   prtc_seq_arbiter #(.GUARD_CYCLES(GUARD), .GW(8)) dut (
      .CLK_14M(clk), .reset(reset), .cen(cen),
      .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_din(cpu_din), .cpu_strobe(cpu_strobe),
      .cpu_dout(cpu_dout), .cpu_collision(cpu_collision),
      .prtc_addr(prtc_addr), .prtc_rw(prtc_rw), .prtc_din(prtc_din), .prtc_strobe(prtc_strobe),
      .prtc_dout(prtc_dout),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_index(req_index),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // cen is high one clock in three, changing on the falling edge
   always @(negedge clk) cyc <= (cyc == 2'd2) ? 2'd0 : cyc + 2'd1;
   assign cen = cyc == 2'd0;
   assign prtc_dout = c033;

   // PRTC model: decodes the command stream and performs the access on the final C034 start beat
   always @(posedge clk) begin
      if (reset) begin
         ph <= 2'd0;
      end else if (cen && prtc_strobe && !prtc_rw) begin
         if (!prtc_addr) c033 <= prtc_din;
         else if (prtc_din[7]) begin
            case (ph)
               2'd0: begin
                  if (c033[6:3] == 4'b0111) begin
                     hi <= c033[2:0]; isclk <= 1'b0; ph <= 2'd1;
                  end else if (c033[6:4] == 3'b000 && c033[1:0] == 2'b01) begin
                     sel <= c033[3:2]; isclk <= 1'b1; ph <= 2'd2;
                  end
               end
               2'd1: begin
                  ad <= {hi, c033[6:2]}; ph <= 2'd2;
               end
               default: begin
                  ph <= 2'd0;
                  if (prtc_din[6]) c033 <= isclk ? clk_data[{sel, 3'b000} +: 8] : pram[ad];
                  else if (isclk) clk_data[{sel, 3'b000} +: 8] <= c033;
                  else pram[ad] <= c033;
               end
            endcase
         end
      end
   end

   // monitor: sequencer beats, response pulses, collisions and leaked CPU strobes
   always @(posedge clk) begin
      if (busy && cen && prtc_strobe && !prtc_rw) obs_q.push_back({prtc_addr, prtc_din});
      if (rsp_valid) rsp_cnt++;
      if (cpu_collision) coll_cnt++;
      if (busy && prtc_strobe && prtc_rw) leak_cnt++;
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cen;
      do step(); while (!cen);
   endtask

   task automatic run_req(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] wd,
                          input logic [7:0] exp_rsp, input int exp_lat, input int inj,
                          output int waits);
      int base, k, ce, r0, nb;
      waits = 0;
      do begin
         wait_cen();
         waits++;
      end while (!req_ready && waits < 400);
      tot_cnt++;
      if (req_ready !== 1'b1) $display("FAIL ready_wait op%0d: req_ready=%b want 1", op, req_ready);
      else pass_cnt++;
      base = obs_q.size();
      r0 = rsp_cnt;
      req_op = op; req_index = idx; req_wdata = wd; req_valid = 1'b1;
      k = 0;
      ce = 0;
      while (!rsp_valid && k < 300) begin
         step();
         k++;
         req_valid = 1'b0;
         cpu_strobe = 1'b0;
         if (cen) begin
            ce++;
            if (ce == inj) begin
               cpu_addr = 1'b0; cpu_rw = 1'b1; cpu_strobe = 1'b1;
               #1;
               tot_cnt++;
               if ({cpu_collision, prtc_rw, prtc_addr} !== 3'b101)
                  $display("FAIL collision_mux: coll/rw/addr=%b want 101", {cpu_collision, prtc_rw, prtc_addr});
               else pass_cnt++;
            end
         end
      end
      tot_cnt++;
      if (k !== exp_lat) $display("FAIL latency op%0d: %0d clocks want %0d", op, k, exp_lat);
      else pass_cnt++;
      tot_cnt++;
      if (rsp_data !== exp_rsp) $display("FAIL rsp_data op%0d: %h want %h", op, rsp_data, exp_rsp);
      else pass_cnt++;
      nb = obs_q.size() - base;
      tot_cnt++;
      if (nb !== exp_q.size()) $display("FAIL beat_count op%0d: %0d want %0d", op, nb, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < nb; i++) begin
         tot_cnt++;
         if (obs_q[base+i] !== exp_q[i])
            $display("FAIL beat%0d op%0d: addr/din=%h want %h", i, op, obs_q[base+i], exp_q[i]);
         else pass_cnt++;
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      tot_cnt++;
      if (rsp_cnt - r0 !== 1 || rsp_valid !== 1'b0)
         $display("FAIL rsp_pulse op%0d: pulses=%0d now=%b want 1 pulse", op, rsp_cnt - r0, rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      cpu_rw = 1'b0;
      repeat (3) step();
      tot_cnt++;
      if ({busy, prtc_rw, prtc_strobe, prtc_addr, rsp_valid, cpu_collision, req_ready} !== 7'b0100000)
         $display("FAIL reset_ctrl: busy/rw/stb/addr/rsp/coll/rdy=%b want 0100000",
                  {busy, prtc_rw, prtc_strobe, prtc_addr, rsp_valid, cpu_collision, req_ready});
      else pass_cnt++;
      tot_cnt++;
      if ({prtc_din, rsp_data} !== 16'h0000) $display("FAIL reset_data: din/rsp=%h want 0000", {prtc_din, rsp_data});
      else pass_cnt++;
      tot_cnt++;
      if (cpu_dout !== c033) $display("FAIL dout_pass: %h want %h", cpu_dout, c033);
      else pass_cnt++;
      cpu_rw = 1'b1;
      reset = 1'b0;
   endtask

   task automatic test_arbitration;
      logic seen;
      int n;
      seen = 1'b0;
      for (int s = 0; s < 6; s++) begin
         for (int j = 0; j < 9; j++) begin
            wait_cen();
            if (req_ready) seen = 1'b1;
         end
         wait_cen();
         cpu_addr = s[0];
         cpu_strobe = 1'b1;
         #1;
         tot_cnt++;
         if ({prtc_strobe, prtc_addr, prtc_rw, req_ready} !== {1'b1, cpu_addr, 1'b1, 1'b0})
            $display("FAIL cpu_fwd%0d: stb/addr/rw/rdy=%b want %b", s,
                     {prtc_strobe, prtc_addr, prtc_rw, req_ready}, {1'b1, cpu_addr, 1'b1, 1'b0});
         else pass_cnt++;
         step();
         cpu_strobe = 1'b0;
         cpu_addr = 1'b0;
      end
      tot_cnt++;
      if (seen !== 1'b0) $display("FAIL busy_cpu_ready: seen=%b want 0", seen);
      else pass_cnt++;
      n = 0;
      do begin
         wait_cen();
         step();
         n++;
      end while (!req_ready && n < 200);
      tot_cnt++;
      if (n !== GUARD) $display("FAIL guard_window: ready after %0d cen want %0d", n, GUARD);
      else pass_cnt++;
   endtask

   task automatic test_bram_write;
      int w;
      exp_q = '{9'h03A, 9'h180, 9'h07C, 9'h180, 9'h0A5, 9'h180};
      run_req(2'd1, 8'h5F, 8'hA5, 8'h00, 19, 0, w);
      tot_cnt++;
      if (pram[8'h5F] !== 8'hA5) $display("FAIL pram_5f: %h want a5", pram[8'h5F]);
      else pass_cnt++;
   endtask

   task automatic test_bram_read;
      int w;
      exp_q = '{9'h0BA, 9'h1C0, 9'h0FC, 9'h1C0, 9'h1C0};
      run_req(2'd0, 8'h5F, 8'h00, 8'hA5, 21, 0, w);
   endtask

   task automatic test_back_to_back;
      int w;
      exp_q = '{9'h08D, 9'h1C0, 9'h1C0};
      run_req(2'd2, 8'h03, 8'h00, 8'h12, 15, 0, w);
      exp_q = '{9'h001, 9'h180, 9'h09A, 9'h180};
      run_req(2'd3, 8'h00, 8'h9A, 8'h00, 13, 0, w);
      tot_cnt++;
      if (w !== 1) $display("FAIL b2b_start: accepted on cen %0d after done want 1", w);
      else pass_cnt++;
      tot_cnt++;
      if (clk_data !== 32'h1234569A) $display("FAIL clock_data: %h want 1234569a", clk_data);
      else pass_cnt++;
   endtask

   task automatic test_collision;
      int w, c0, l0;
      c0 = coll_cnt;
      l0 = leak_cnt;
      exp_q = '{9'h038, 9'h180, 9'h048, 9'h180, 9'h03C, 9'h180};
      run_req(2'd1, 8'h12, 8'h3C, 8'h00, 19, 4, w);
      tot_cnt++;
      if (coll_cnt - c0 !== 1 || leak_cnt - l0 !== 0)
         $display("FAIL collision_count: pulses=%0d leaks=%0d want 1 and 0", coll_cnt - c0, leak_cnt - l0);
      else pass_cnt++;
      tot_cnt++;
      if (pram[8'h12] !== 8'h3C) $display("FAIL pram_12: %h want 3c", pram[8'h12]);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int n, base, r0;
      n = 0;
      do begin
         wait_cen();
         n++;
      end while (!req_ready && n < 400);
      base = obs_q.size();
      r0 = rsp_cnt;
      req_op = 2'd0; req_index = 8'h5F; req_valid = 1'b1;
      wait_cen();
      req_valid = 1'b0;
      wait_cen();
      step();
      cpu_rw = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      tot_cnt++;
      if ({busy, prtc_rw, prtc_strobe} !== 3'b010)
         $display("FAIL mid_reset: busy/rw/stb=%b want 010", {busy, prtc_rw, prtc_strobe});
      else pass_cnt++;
      step();
      reset = 1'b0;
      cpu_rw = 1'b1;
      repeat (60) step();
      tot_cnt++;
      if (rsp_cnt !== r0 || obs_q.size() - base !== 2)
         $display("FAIL mid_reset_quiet: rsp=%0d beats=%0d want 0 and 2", rsp_cnt - r0, obs_q.size() - base);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_bram_write();
      test_bram_read();
      test_back_to_back();
      test_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/prtc_seq_arbiter.md
Name: prtc_seq_arbiter

Overview:
- Shares the PRTC's C033/C034 register pair between the CPU and an internal requester, such as the HPS NVRAM save/load engine or a clock-set path.
- On each request it issues the full PRTC command/control/data beat sequence for one BRAM byte or one clock byte, read or write.
- The CPU owns the port by default. The sequencer takes the port only after a CPU-quiet window, and blocks CPU strobes for the length of its sequence.

Parameters:
- GUARD_CYCLES, 64: number of consecutive cen ticks with no CPU strobe required before a request may start.
- GW, 8: width of the guard counter; must satisfy 2^GW > GUARD_CYCLES.

Ports:
- CLK_14M in 1: system clock.
- reset in 1: synchronous, active-high.
- cen in 1: PRTC clock enable; every beat is issued on a cen cycle.
- cpu_addr in 1: 0 = C033, 1 = C034.
- cpu_rw in 1: 1 = read.
- cpu_din in 8: CPU write data.
- cpu_strobe in 1: CPU access strobe (one cen).
- cpu_dout out 8: prtc_dout passed through.
- cpu_collision out 1: one-cycle pulse when a CPU strobe is blocked.
- prtc_addr out 1, prtc_rw out 1, prtc_din out 8, prtc_strobe out 1: drive the PRTC.
- prtc_dout in 8: PRTC read data.
- req_valid in 1: request present.
- req_ready out 1: request may be accepted.
- req_op in 2: 0 BRAM read, 1 BRAM write, 2 clock read, 3 clock write.
- req_index in 8: BRAM address; for clock ops [1:0] is the byte number.
- req_wdata in 8: write data.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_data out 8: read byte; 0x00 for write ops.
- busy out 1: high when state is not IDLE.

Behaviour:
- Reset values: state IDLE, guard counter 0, rsp_valid 0, rsp_data 0x00, cpu_collision 0, busy 0, prtc_strobe 0, prtc_rw 1, prtc_addr 0, prtc_din 0x00.
- prtc_rw idle rule: the PRTC latches C033/C034 on any cycle where rw=0, strobe or not. prtc_rw is therefore 0 only on the single CLK_14M cycle of a write beat, and 1 everywhere else.
- Port mux in IDLE: prtc_* equal cpu_*; prtc_strobe = cpu_strobe.
- Port mux when not IDLE: the sequencer drives prtc_*. cpu_strobe&cen is dropped and pulses cpu_collision.
- Guard counter, on each cen:
  - clears to 0 on cpu_strobe;
  - otherwise increments, saturating at GUARD_CYCLES;
  - quiet = (count == GUARD_CYCLES).
- req_ready = IDLE & quiet & ~cpu_strobe.
- Accept on req_valid & req_ready & cen; latch op, index and wdata.
- Beat definition: one cen cycle with prtc_strobe=1 and prtc_rw=0.
  - W33(x) means prtc_addr=0, prtc_din=x.
  - W34 means prtc_addr=1, prtc_din={1, rd, 6'b0}, where rd = ~op[0].
  - Every W34 carries the read flag, because the PRTC samples its stored C034 bit 6 from the previous write.
- States; each advances on the next cen after the previous beat:
  - CMD_A: W33. For BRAM: {rd, 4'b0111, idx[7:5]}. For clock: {rd, 3'b000, idx[1:0], 2'b01}.
  - CTL_A: W34. Then go to CMD_B for BRAM, or to DATA for clock.
  - CMD_B: W33({rd, idx[4:0], 2'b00}).
  - CTL_B: W34.
  - DATA: W33(wdata) for write ops; no beat for reads (state passes through on cen).
  - CTL_D: W34. The PRTC performs its access on this beat.
  - RD_ADDR (reads only): prtc_addr=0, prtc_rw=1, no strobe. Hold for one CLK_14M cycle.
  - RD_CAP: rsp_data <= prtc_dout (the latched C033).
  - DONE: rsp_valid=1 for one CLK_14M cycle, then IDLE.
- Writes go from CTL_D directly to DONE; rsp_data=0x00.
- Latency from accept to rsp_valid:
  - BRAM write: 6 cen.
  - BRAM read: 6 cen + 2 clocks.
  - Clock write: 4 cen.
  - Clock read: 4 cen + 2 clocks.
  - Add 1 clock for DONE in every case.
- Back-to-back requests are allowed. The guard counter is not cleared by sequencer beats, so the next request may start the cen after DONE.
- Reset mid-sequence: returns to IDLE immediately with no further beats. PRTC protocol recovery is the system reset's responsibility.
- cpu_strobe and accept in the same cycle: the CPU wins; req_ready is already 0.

Decomposition:
- prtc_pkg holds:
  - op encodings (OP_BRAM_RD, OP_BRAM_WR, OP_CLK_RD, OP_CLK_WR);
  - the C034 bit indices (START=7, READ=6);
  - the command prefixes 4'b0111 (extended BRAM) and 3'b000 plus 2'b01 (clock);
  - the state enum.
- One combinational sub-module, prtc_cmd_encode: maps (state, op, index, wdata) to prtc_addr/prtc_din.
- The FSM, guard counter and mux remain in the top module.

Test Plan:
- BRAM write: idx 0x5F, data 0xA5 → beats 33=0x3A, 34=0x80, 33=0x7C, 34=0x80, 33=0xA5, 34=0x80. PRTC pram[0x5F]=0xA5. rsp_valid with 0x00.
- BRAM read: idx 0x5F after the write above → beats 33=0xBA, 34=0xC0, 33=0xFC, 34=0xC0, 34=0xC0. rsp_data=0xA5.
- Clock read: byte 3, PRTC clock_data 0x12345678 → beats 33=0x8D, 34=0xC0, 34=0xC0. rsp_data=0x12.
- Clock write: byte 0, data 0x9A → beats 33=0x01, 34=0x80, 33=0x9A, 34=0x80. clock_data[7:0]=0x9A.
- Arbitration:
  - A CPU strobe every 10 cen keeps req_ready=0.
  - After the CPU stops, req_ready rises exactly GUARD_CYCLES cen later.
  - A CPU strobe injected during CTL_B is not forwarded and cpu_collision pulses once.
- Reset asserted in CMD_B → next cycle busy=0, prtc_rw=1, prtc_strobe=0, rsp_valid never asserts.
